// File: rtl/head_scan_pkg.sv
// head_scan_pkg: shared widths, FSM encoding and the grant-clear mask helper
// for the head_scan_sched block.
package head_scan_pkg;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned POS_W  = 6;
    localparam int unsigned STAT_W = 16;

    typedef enum logic {
        StIdle = 1'b0,
        StEmit = 1'b1
    } state_e;

    // One-hot mask of bit (WIDTH-1-pos); all-zero when pos is out of range
    // (the finder reports WIDTH for an empty vector).
    function automatic logic [WIDTH-1:0] pos_mask(input logic [POS_W-1:0] pos);
        logic [WIDTH-1:0] m;
        m = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (pos == POS_W'(WIDTH - 1 - i)) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/head_detect.sv
// head_detect: combinational leading-one finder. Reports the position of the
// highest set bit counted from the MSB (bit 31 -> 0); reports WIDTH when the
// input is all-zero.
module head_detect
    import head_scan_pkg::*;
(
    input  logic [WIDTH-1:0] data_in,
    output logic [POS_W-1:0] pos_out
);

    // Scan upward so the highest set bit is the last assignment to win.
    always_comb begin
        pos_out = POS_W'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (data_in[i]) begin
                pos_out = POS_W'(WIDTH - 1 - i);
            end
        end
    end

endmodule

// File: rtl/head_scan_sched.sv
// head_scan_sched: accepts a request vector and issues one grant per beat,
// highest-numbered pending bit first, clearing each bit on its handshake.
// Optional statistics counters are enabled with HEAD_SCAN_STATS_EN.
module head_scan_sched
    import head_scan_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             vec_valid,
    output logic             vec_ready,
    input  logic [WIDTH-1:0] vec_data,
    input  logic             flush,
    output logic             grant_valid,
    input  logic             grant_ready,
    output logic [POS_W-1:0] grant_pos,
    output logic             grant_last,
    output logic             grant_empty,
    output logic [POS_W-1:0] grant_idx,
    output logic             busy
`ifdef HEAD_SCAN_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_vecs,
    output logic [STAT_W-1:0] stat_grants
`endif
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pending_q, pending_d;
    logic [POS_W-1:0] idx_q, idx_d;
    logic             empty_q, empty_d;

    logic [POS_W-1:0] lod_pos;
    logic [WIDTH-1:0] remain;
    logic             is_last;
    logic             vec_accept;
    logic             grant_fire;

    head_detect u_head_detect (
        .data_in (pending_q),
        .pos_out (lod_pos)
    );

    assign remain     = pending_q & ~pos_mask(lod_pos);
    assign is_last    = empty_q | (remain == '0);
    assign vec_accept = (state_q == StIdle) & vec_valid;
    assign grant_fire = (state_q == StEmit) & grant_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: leave EMIT on flush or on the handshake of the final beat.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (vec_valid) state_d = StEmit;
            StEmit: if (flush || (grant_ready && is_last)) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Datapath next-state: load on accept, clear granted bit on handshake.
    always_comb begin
        pending_d = pending_q;
        idx_d     = idx_q;
        empty_d   = empty_q;
        if (vec_accept) begin
            pending_d = vec_data;
            idx_d     = '0;
            empty_d   = (vec_data == '0);
        end else if (state_q == StEmit) begin
            if (grant_fire) begin
                pending_d = remain;
                idx_d     = idx_q + POS_W'(1);
            end
            // Any same-cycle handshake still counts; the rest is dropped.
            if (flush) begin
                pending_d = '0;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
            idx_q     <= '0;
            empty_q   <= 1'b0;
        end else begin
            pending_q <= pending_d;
            idx_q     <= idx_d;
            empty_q   <= empty_d;
        end
    end

    // Outputs: grant fields are forced to zero outside EMIT.
    always_comb begin
        vec_ready   = (state_q == StIdle);
        grant_valid = (state_q == StEmit);
        busy        = (state_q != StIdle);
        grant_pos   = '0;
        grant_idx   = '0;
        grant_last  = 1'b0;
        grant_empty = 1'b0;
        if (state_q == StEmit) begin
            grant_pos   = lod_pos;
            grant_idx   = idx_q;
            grant_last  = is_last;
            grant_empty = empty_q;
        end
    end

`ifdef HEAD_SCAN_STATS_EN
    // Saturating counters of accepted vectors and completed grant handshakes.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_vecs   <= '0;
            stat_grants <= '0;
        end else begin
            if (vec_accept && (stat_vecs != '1)) begin
                stat_vecs <= stat_vecs + STAT_W'(1);
            end
            if (grant_fire && (stat_grants != '1)) begin
                stat_grants <= stat_grants + STAT_W'(1);
            end
        end
    end
`endif

endmodule
